decompressor: RTL

- Consumes 64-bit compressed words that the outmap compressor wrote to memory and expands them back into a packed byte stream for the next layer's input buffer.
- Sits between the memory read port and the input-map loader.
- Accepts one word at a time via a valid/ready handshake, expands one group at a time into a 16-byte accumulator, and emits 16-byte beats with a valid count.
- A word tagged in_last causes a partial-beat flush marked out_last.

---
 rtl/decompressor_if.sv | 23 ++
 rtl/decompressor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decompressor_if.sv
// Stream bundle between the memory read port, the decompressor and the input-map loader.
// The slave view belongs to the decompressor; the master view drives words in and accepts beats.
interface decompressor_if;
  logic [63:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [15:0][7:0] out_data;
  logic [4:0]       out_valid_num;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid_num, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid_num, out_last, out_valid
  );
endinterface

// File: rtl/decompressor.sv
// Expands (zero-run, value) compressed words back into packed 16-byte beats
// for the next layer's input buffer.
module decompressor #(
  parameter int OUT_LANES  = 16,
  parameter int NUM_GROUPS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  decompressor_if.slave io,
  output logic          fmt_err_o
);

  typedef enum logic [1:0] {IDLE, EXPAND, FLUSH} state_t;

  localparam logic [2:0] MAX_N = 3'(NUM_GROUPS);
  localparam logic [4:0] FULL  = 5'(OUT_LANES);

  state_t                        state_q, state_d;
  logic [59:0]                   groups_q, groups_d;
  logic                          e_q, e_d;
  logic                          last_q, last_d;
  logic [2:0]                    grp_q, grp_d;
  logic [2:0]                    n_q, n_d;
  logic [4:0]                    zrem_q, zrem_d;
  logic                          vpend_q, vpend_d;
  logic [OUT_LANES-1:0][7:0]     acc_q, acc_d;
  logic [4:0]                    cnt_q, cnt_d;
  logic [15:0][7:0]              odata_q, odata_d;
  logic [4:0]                    onum_q, onum_d;
  logic                          olast_q, olast_d;
  logic                          ovalid_q, ovalid_d;
  logic                          fmt_err_q, fmt_err_d;

  logic [2:0] nRaw;
  logic [4:0] groupLeft, space, take, zTake, newCnt;
  logic       vTake, exhausted, done, outFree;
  logic [7:0] curV;
  logic [3:0] zNext;

  function automatic logic [15:0][7:0] maskLanes(input logic [15:0][7:0] a, input logic [4:0] cnt);
    logic [15:0][7:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(cnt)) m[i] = a[i];
    end
    return m;
  endfunction

  assign io.in_ready      = rst_n && (state_q == IDLE);
  assign io.out_data      = odata_q;
  assign io.out_valid_num = onum_q;
  assign io.out_last      = olast_q;
  assign io.out_valid     = ovalid_q;
  assign fmt_err_o        = fmt_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      groups_q  <= '0;
      e_q       <= 1'b0;
      last_q    <= 1'b0;
      grp_q     <= '0;
      n_q       <= '0;
      zrem_q    <= '0;
      vpend_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      odata_q   <= '0;
      onum_q    <= '0;
      olast_q   <= 1'b0;
      ovalid_q  <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      groups_q  <= groups_d;
      e_q       <= e_d;
      last_q    <= last_d;
      grp_q     <= grp_d;
      n_q       <= n_d;
      zrem_q    <= zrem_d;
      vpend_q   <= vpend_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      odata_q   <= odata_d;
      onum_q    <= onum_d;
      olast_q   <= olast_d;
      ovalid_q  <= ovalid_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    groups_d  = groups_q;
    e_d       = e_q;
    last_d    = last_q;
    grp_d     = grp_q;
    n_d       = n_q;
    zrem_d    = zrem_q;
    vpend_d   = vpend_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    odata_d   = odata_q;
    onum_d    = onum_q;
    olast_d   = olast_q;
    ovalid_d  = ovalid_q;
    fmt_err_d = fmt_err_q;

    nRaw      = io.in_data[62:60];
    curV      = 8'(groups_q >> (32'(grp_q - 3'd1) * 32'd12 + 32'd4));
    zNext     = 4'(groups_q >> (32'(grp_q) * 32'd12));
    groupLeft = zrem_q + {4'd0, vpend_q};
    space     = FULL - cnt_q;
    take      = (space < groupLeft) ? space : groupLeft;
    zTake     = (take < zrem_q) ? take : zrem_q;
    vTake     = vpend_q && (take > zrem_q);
    newCnt    = cnt_q + take;
    exhausted = (take == groupLeft);
    done      = exhausted && (grp_q >= n_q);
    outFree   = !ovalid_q || io.out_ready;

    if (ovalid_q && io.out_ready) ovalid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.in_valid && io.in_ready) begin
          groups_d = io.in_data[59:0];
          e_d      = io.in_data[63];
          last_d   = io.in_last;
          grp_d    = 3'd1;
          n_d      = (nRaw > MAX_N) ? MAX_N : nRaw;
          if (nRaw > MAX_N) fmt_err_d = 1'b1;
          zrem_d   = (n_d == 3'd0) ? 5'd0 : {1'b0, io.in_data[3:0]};
          vpend_d  = (n_d != 3'd0) && !(n_d == 3'd1 && !io.in_data[63]);
          state_d  = EXPAND;
        end
      end

      EXPAND: begin
        for (int i = 0; i < OUT_LANES; i++) begin
          if (i >= int'(cnt_q) && i < int'(newCnt))
            acc_d[i] = (i - int'(cnt_q) < int'(zTake)) ? 8'h00 : curV;
        end
        zrem_d  = zrem_q - zTake;
        vpend_d = vpend_q && !vTake;
        if (exhausted && !done) begin
          grp_d   = grp_q + 3'd1;
          zrem_d  = {1'b0, zNext};
          vpend_d = !((grp_q + 3'd1) == n_q && !e_q);
        end
        // A full accumulator goes straight to the output register when it is free;
        // otherwise it parks at 16 and expansion stalls (take becomes 0).
        if (newCnt == FULL) begin
          if (outFree) begin
            ovalid_d = 1'b1;
            odata_d  = acc_d;
            onum_d   = FULL;
            olast_d  = done && last_q;
            cnt_d    = 5'd0;
            if (done) state_d = IDLE;
          end else begin
            cnt_d = newCnt;
          end
        end else begin
          cnt_d = newCnt;
          if (done) state_d = last_q ? FLUSH : IDLE;
        end
      end

      FLUSH: begin
        if (cnt_q == 5'd0) begin
          state_d = IDLE;
        end else if (outFree) begin
          ovalid_d = 1'b1;
          odata_d  = maskLanes(acc_q, cnt_q);
          onum_d   = cnt_q;
          olast_d  = 1'b1;
          cnt_d    = 5'd0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
